// File: rtl/bram_mask_pwm_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_mask_pwm_mc_if
// Purpose  : AXI-Stream video beat bundle (data, valid, ready, last, user)
//            with master/slave views for the masking pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_mask_pwm_mc_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/bram_mask_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module   : bram_mask_pwm_mc
// Purpose  : Two-stage video pipeline that gates each pixel with per-channel
//            BRAM mask bits, each channel dimmed by frame-rate PWM brightness.
// Revision : 1.0 - initial release
// ============================================================================
module bram_mask_pwm_mc #(
  parameter int DW    = 16,
  parameter int BW    = 32,
  parameter int NCH   = 2,
  parameter int PB    = 3,
  parameter int DEPTH = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [NCH-1:0]          bram_clk,
  output logic [NCH-1:0]          bram_rst,
  output logic [NCH-1:0]          bram_en,
  output logic [NCH-1:0]          bram_we,
  output logic [NCH*32-1:0]       bram_addr,
  output logic [NCH*BW-1:0]       bram_din,
  input  logic [NCH*BW-1:0]       bram_dout,
  bram_mask_pwm_mc_if.slave       v_s,
  bram_mask_pwm_mc_if.master      v_m,
  input  logic [NCH*(PB+1)-1:0]   bright,
  input  logic                    mode,
  output logic [PB-1:0]           pwm_slot
);
  localparam int PPW = BW / DW;
  localparam int P   = 1 << PB;
  localparam int WW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BPW = BW / 8;

  // Lit test for one channel: the frame is lit when (s+1)*b/P and s*b/P fall
  // in different integer bins, which spreads exactly b lit frames over P.
  function automatic logic pwm_on(input logic [PB-1:0] s, input logic [PB:0] b);
    logic [2*PB+1:0] lo;
    logic [2*PB+1:0] hi;
    lo = (2*PB+2)'(s) * (2*PB+2)'(b);
    hi = lo + (2*PB+2)'(b);
    return hi[2*PB+1:PB] != lo[2*PB+1:PB];
  endfunction

  logic                  advance;
  logic                  accept;
  logic [WW-1:0]         word;
  logic [LW-1:0]         lane;
  logic [LW-1:0]         beat_lane;
  logic [31:0]           word_addr;
  logic [PB-1:0]         slot_inc;
  logic [PB-1:0]         beat_slot;
  logic [NCH-1:0][PB:0]  bright_clamp;
  logic [NCH-1:0][PB:0]  beat_bright;
  logic [NCH-1:0][PB:0]  frame_bright;
  logic                  beat_mode;
  logic                  frame_mode;

  logic                  s1_valid;
  logic [DW-1:0]         s1_data;
  logic                  s1_last;
  logic                  s1_user;
  logic [LW-1:0]         s1_lane;
  logic [PB-1:0]         s1_slot;
  logic [NCH-1:0][PB:0]  s1_bright;
  logic                  s1_mode;

  logic [NCH-1:0]        chan_on;
  logic [DW-1:0]         mask;
  logic [DW-1:0]         masked;

  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic                  out_user;

  // The whole pipeline, BRAM read port included, moves only when the output
  // slot is free or being drained this cycle.
  assign advance    = ~out_valid | v_m.tready;
  assign accept     = v_s.tvalid & advance;
  assign v_s.tready = advance;

  assign bram_clk  = {NCH{clk}};
  assign bram_rst  = {NCH{~rst_n}};
  assign bram_en   = {NCH{advance}};
  assign bram_we   = '0;
  assign bram_din  = '0;

  // A tuser beat always starts the frame at word 0 lane 0.
  assign word_addr = v_s.tuser ? 32'd0 : 32'(word) * 32'(BPW);
  assign bram_addr = {NCH{word_addr}};
  assign beat_lane = v_s.tuser ? '0 : lane;

  // Controls that travel with an incoming beat: a tuser beat carries the new
  // frame's values so the frame's first pixel already uses them.
  assign slot_inc  = pwm_slot + 1'b1;
  assign beat_slot = v_s.tuser ? slot_inc : pwm_slot;
  assign beat_mode = v_s.tuser ? mode : frame_mode;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign bright_clamp[c] = (bright[c*(PB+1) +: PB+1] > (PB+1)'(P)) ?
                             (PB+1)'(P) : bright[c*(PB+1) +: PB+1];
    assign beat_bright[c]  = v_s.tuser ? bright_clamp[c] : frame_bright[c];
    assign chan_on[c]      = pwm_on(s1_slot, s1_bright[c]);
  end

  // Word/lane walk through the mask; tuser rewinds, lane wrap bumps the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      lane <= '0;
    end else if (accept) begin
      if (v_s.tuser) begin
        if (PPW == 1) begin
          word <= (DEPTH > 1) ? WW'(1) : '0;
          lane <= '0;
        end else begin
          word <= '0;
          lane <= LW'(1);
        end
      end else if (lane == LW'(PPW - 1)) begin
        lane <= '0;
        word <= (word == WW'(DEPTH - 1)) ? '0 : word + 1'b1;
      end else begin
        lane <= lane + 1'b1;
      end
    end
  end

  // Frame-level registers update once per accepted start-of-frame beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_slot     <= '1;
      frame_bright <= '0;
      frame_mode   <= 1'b0;
    end else if (accept && v_s.tuser) begin
      pwm_slot     <= slot_inc;
      frame_bright <= bright_clamp;
      frame_mode   <= mode;
    end
  end

  // Stage 1: beat waits here while its BRAM word is being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_last   <= 1'b0;
      s1_user   <= 1'b0;
      s1_lane   <= '0;
      s1_slot   <= '0;
      s1_bright <= '0;
      s1_mode   <= 1'b0;
    end else if (advance) begin
      s1_valid  <= v_s.tvalid;
      s1_data   <= v_s.tdata;
      s1_last   <= v_s.tlast;
      s1_user   <= v_s.tuser;
      s1_lane   <= beat_lane;
      s1_slot   <= beat_slot;
      s1_bright <= beat_bright;
      s1_mode   <= beat_mode;
    end
  end

  // Combine the selected lane of every lit channel into one pixel mask.
  always_comb begin
    mask = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chan_on[c]) begin
        for (int i = 0; i < PPW; i++) begin
          if (s1_lane == LW'(i)) begin
            mask = mask | bram_dout[c*BW + BW - 1 - i*DW -: DW];
          end
        end
      end
    end
  end

  assign masked = s1_mode ? (s1_data & ~mask) : (s1_data & mask);

  // Stage 2: registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= masked;
      out_last  <= s1_last;
      out_user  <= s1_user;
    end
  end

  assign v_m.tvalid = out_valid;
  assign v_m.tdata  = out_data;
  assign v_m.tlast  = out_last;
  assign v_m.tuser  = out_user;
endmodule
`default_nettype wire

// File: tb/tb_bram_mask_pwm_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_mask_pwm_mc
// Purpose  : Directed self-checking bench for bram_mask_pwm_mc (NCH=2, PB=3,
//            DW=16, BW=32, DEPTH=4) with a simple BRAM read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_mask_pwm_mc;
  localparam int DW = 16, BW = 32, NCH = 2, PB = 3, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]        bram_clk, bram_rst, bram_en, bram_we;
  logic [NCH*32-1:0]     bram_addr;
  logic [NCH*BW-1:0]     bram_din;
  logic [NCH*BW-1:0]     bram_dout = '0;
  logic [NCH*(PB+1)-1:0] bright;
  logic                  mode;
  logic [PB-1:0]         pwm_slot;

  bram_mask_pwm_mc_if #(.DW(DW)) v_s ();
  bram_mask_pwm_mc_if #(.DW(DW)) v_m ();

  bram_mask_pwm_mc #(.DW(DW), .BW(BW), .NCH(NCH), .PB(PB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .v_s(v_s), .v_m(v_m),
    .bright(bright), .mode(mode), .pwm_slot(pwm_slot)
  );

  // BRAM model: registered read, output held while the enable is low.
  logic [31:0] mem0 [4];
  logic [31:0] mem1 [4];
  always @(posedge clk) begin
    if (bram_en[0]) bram_dout[31:0]  <= mem0[bram_addr[3:2]];
    if (bram_en[1]) bram_dout[63:32] <= mem1[bram_addr[35:34]];
  end

  // Beat recorders: every output handshake and every input acceptance.
  typedef struct { logic [15:0] d; logic u; logic l; int cyc; } obs_t;
  typedef struct { logic [31:0] a0; logic [31:0] a1; int cyc; } acc_t;
  obs_t obs_q[$];
  acc_t acc_q[$];
  int   cyc = 0;
  always @(posedge clk) begin
    obs_t o;
    acc_t a;
    cyc <= cyc + 1;
    if (rst_n && v_m.tvalid && v_m.tready) begin
      o.d = v_m.tdata; o.u = v_m.tuser; o.l = v_m.tlast; o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (rst_n && v_s.tvalid && v_s.tready) begin
      a.a0 = bram_addr[31:0]; a.a1 = bram_addr[63:32]; a.cyc = cyc;
      acc_q.push_back(a);
    end
  end

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp_a[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bright(input logic [3:0] b0, input logic [3:0] b1);
    bright = {b1, b0};
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
    int   n;
    logic rdy;
    n = 0;
    v_s.tdata = d; v_s.tuser = u; v_s.tlast = l; v_s.tvalid = 1'b1;
    do begin
      @(negedge clk);
      rdy = v_s.tready;
      step();
      n++;
    end while (!rdy && n < 50);
    check("send_accept", {31'd0, rdy}, 32'd1);
    v_s.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    v_s.tvalid = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check("rst_m_tvalid", {31'd0, v_m.tvalid}, 32'd0);
    check("rst_m_tdata", {16'd0, v_m.tdata}, 32'd0);
    check("rst_m_tlast_tuser", {30'd0, v_m.tlast, v_m.tuser}, 32'd0);
    check("rst_pwm_slot", {29'd0, pwm_slot}, 32'd7);
    check("rst_s_tready", {31'd0, v_s.tready}, 32'd1);
    check("rst_bram_rst_we", {28'd0, bram_rst, bram_we}, 32'hC);
    rst_n = 1'b1;
    step();
    check("post_rst_s_tready", {31'd0, v_s.tready}, 32'd1);
    obs_q.delete();
    acc_q.delete();
  endtask

  task automatic expect_out(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 60) begin step(); n++; end
    repeat (4) step();
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_d%0d", tag, i), {16'd0, obs_q[i].d}, {16'd0, exp_q[i]});
  endtask

  task automatic expect_addr(input string tag);
    check({tag, "_acount"}, acc_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < acc_q.size(); i++) begin
      check($sformatf("%s_a0_%0d", tag, i), acc_q[i].a0, exp_a[i]);
      check($sformatf("%s_a1_%0d", tag, i), acc_q[i].a1, exp_a[i]);
    end
  endtask

  task automatic clear_q();
    obs_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v_s.tvalid = 1'b0; v_s.tdata = '0; v_s.tuser = 1'b0; v_s.tlast = 1'b0;
    v_m.tready = 1'b1;
    bright = '0; mode = 1'b0;
    mem0 = '{32'hFFFF0000, 32'h0F0F00FF, 32'h1234F0F0, 32'hAAAA5555};
    mem1 = '{32'h0F0FF000, 32'h0, 32'h0, 32'h0};

    // Basic frame: 10 pixels, word wrap at DEPTH=4, latency 2.
    do_reset();
    set_bright(4'd8, 4'd0); mode = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(16'hABCD, i == 0, i == 9);
    check("t1_slot", {29'd0, pwm_slot}, 32'd0);
    exp_q = '{16'hABCD, 16'h0000, 16'h0B0D, 16'h00CD, 16'h0204,
              16'hA0C0, 16'hAA88, 16'h0145, 16'hABCD, 16'h0000};
    expect_out("t1");
    check("t1_latency0", obs_q[0].cyc - acc_q[0].cyc, 32'd2);
    check("t1_latency5", obs_q[5].cyc - acc_q[5].cyc, 32'd2);
    check("t1_user_first", {31'd0, obs_q[0].u}, 32'd1);
    check("t1_user_second", {31'd0, obs_q[1].u}, 32'd0);
    check("t1_last", {30'd0, obs_q[8].l, obs_q[9].l}, 32'd1);
    exp_a = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12, 32'd12, 32'd0, 32'd0};
    expect_addr("t1");
    clear_q();

    // Channel 1 only; controls changed mid-frame must not affect this frame.
    set_bright(4'd0, 4'd8); mode = 1'b0;
    send_beat(16'hFFFF, 1'b1, 1'b0);
    set_bright(4'd0, 4'd0); mode = 1'b1;
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b1);
    check("t2_slot", {29'd0, pwm_slot}, 32'd1);
    exp_q = '{16'h0F0F, 16'hF000, 16'h0000, 16'h0000};
    expect_out("t2");
    clear_q();
    mode = 1'b0;

    // PWM: bright 4 lights odd slots; bright 9 saturates to all slots.
    do_reset();
    set_bright(4'd4, 4'd0);
    exp_q.delete();
    for (int f = 0; f < 8; f++) begin
      send_beat(16'hFFFF, 1'b1, 1'b1);
      check($sformatf("t3_slot_b4_%0d", f), {29'd0, pwm_slot}, f);
      exp_q.push_back((f % 2 == 1) ? 16'hFFFF : 16'h0000);
    end
    set_bright(4'd9, 4'd0);
    for (int f = 0; f < 8; f++) begin
      send_beat(16'hFFFF, 1'b1, 1'b1);
      check($sformatf("t3_slot_b9_%0d", f), {29'd0, pwm_slot}, f);
      exp_q.push_back(16'hFFFF);
    end
    expect_out("t3");
    clear_q();

    // Output stall of 5 cycles mid-frame.
    do_reset();
    mem0 = '{32'hFFFF0000, 32'h1234F0F0, 32'hAAAA5555, 32'h0};
    set_bright(4'd8, 4'd0); mode = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(16'hFFFF, i == 0, i == 5);
      end
      begin
        step(); step(); step();
        v_m.tready = 1'b0;
        step(); step();
        check("t4_bram_en", {30'd0, bram_en}, 32'd0);
        check("t4_s_tready", {31'd0, v_s.tready}, 32'd0);
        check("t4_hold_valid", {31'd0, v_m.tvalid}, 32'd1);
        step(); step(); step();
        v_m.tready = 1'b1;
      end
    join
    exp_q = '{16'hFFFF, 16'h0000, 16'h1234, 16'hF0F0, 16'hAAAA, 16'h5555};
    expect_out("t4");
    clear_q();

    // Blanking mode with an all-ones mask.
    do_reset();
    mem0 = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    mode = 1'b1; set_bright(4'd8, 4'd0);
    send_beat(16'h5A5A, 1'b1, 1'b0);
    send_beat(16'hC3C3, 1'b0, 1'b1);
    set_bright(4'd0, 4'd0);
    send_beat(16'h5A5A, 1'b1, 1'b0);
    send_beat(16'hC3C3, 1'b0, 1'b1);
    exp_q = '{16'h0000, 16'h0000, 16'h5A5A, 16'hC3C3};
    expect_out("t5");
    clear_q();

    // Reset with two beats in flight; the next frame starts clean.
    mem0 = '{32'hFFFF0000, 32'h0F0F00FF, 32'h0, 32'h0};
    mode = 1'b0; set_bright(4'd8, 4'd0);
    send_beat(16'hABCD, 1'b1, 1'b0);
    send_beat(16'hABCD, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check("t6_valid_dropped", {31'd0, v_m.tvalid}, 32'd0);
    check("t6_slot_reset", {29'd0, pwm_slot}, 32'd7);
    step();
    rst_n = 1'b1;
    step(); step();
    check("t6_no_beat", obs_q.size(), 32'd0);
    clear_q();
    for (int i = 0; i < 3; i++) send_beat(16'hABCD, i == 0, i == 2);
    check("t6_slot", {29'd0, pwm_slot}, 32'd0);
    exp_q = '{16'hABCD, 16'h0000, 16'h0B0D};
    expect_out("t6");
    exp_a = '{32'd0, 32'd0, 32'd4};
    expect_addr("t6");
    clear_q();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bram_mask_pwm_mc.md
BRAM_MASK_PWM_MC -- requirements
Module: bram_mask_pwm_mc

Parameters
REQ-001 SHALL provide DW, default 16, pixel data width in bits.
REQ-002 SHALL provide BW, default 32, BRAM word width; legal only when BW is an integer multiple of DW. PPW = BW/DW pixels per word.
REQ-003 SHALL provide NCH, default 2, number of mask channels (1..8).
REQ-004 SHALL provide PB, default 3, PWM resolution bits; period P = 2^PB frames.
REQ-005 SHALL provide DEPTH, default 65536, mask words per channel.

Interface
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 bram_clk, bram_rst, bram_en, bram_we  out  NCH each  per channel: clk, ~rst_n, read enable, constant 0.
REQ-009 bram_addr  out  NCH*32  per-channel byte address; bram_din  out  NCH*BW  constant 0.
REQ-010 bram_dout  in  NCH*BW  per-channel read data, valid one cycle after an enabled address.
REQ-011 v_s_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DW/1/1/1/1  AXI-Stream video input; tuser marks first pixel of a frame.
REQ-012 v_m_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DW/1/1/1/1  AXI-Stream video output.
REQ-013 bright  in  NCH*(PB+1)  per-channel brightness, 0..P; values above P SHALL be treated as P.
REQ-014 mode  in  1  0 = pass pixels where mask lit, 1 = blank pixels where mask lit.
REQ-015 pwm_slot  out  PB  current frame's PWM slot.

Function
REQ-016 Pipeline SHALL have 2 stages (S1: BRAM read, S2: output register); advance = ~v_m_tvalid | v_m_tready.
REQ-017 v_s_tready SHALL equal advance; a beat is accepted when v_s_tvalid & advance.
REQ-018 On advance, S1 and S2 SHALL shift (valid, data, last, user, lane, latched controls); otherwise all stage registers SHALL hold.
REQ-019 bram_en SHALL equal advance on all channels, so bram_dout stays stable while stalled.
REQ-020 Latency: a beat accepted at edge k SHALL appear on v_m_* after edge k+2 if no stall occurs.
REQ-021 Address counters SHALL be a word index and a lane index (0..PPW-1).
REQ-022 bram_addr SHALL be 0 when v_s_tuser is high, otherwise word*(BW/8), identical on all channels.
REQ-023 An accepted tuser beat SHALL read word 0, lane 0. The next lane SHALL then be 1 (or 0 with word 1 when PPW=1).
REQ-024 Each accepted non-tuser beat SHALL use the current word and lane, then advance the lane.
REQ-025 At lane wrap the word SHALL increment, wrapping from DEPTH-1 to 0.
REQ-026 A cycle without acceptance SHALL leave the address counters unchanged.
REQ-027 Lane 0 SHALL select bram_dout bits [BW-1:BW-DW]; lane i SHALL select the next lower DW bits.
REQ-028 Per channel c, on(c) = floor((s+1)*b_c/P) != floor(s*b_c/P), with s = pwm_slot and b_c = latched brightness; this yields exactly b_c lit frames per period.
REQ-029 mask = OR over c of (lane bits of channel c, gated by on(c)).
REQ-030 v_m_tdata SHALL be pixel & mask in mode 0, and pixel & ~mask in mode 1.
REQ-031 mode SHALL be latched with the beat in S1.
REQ-032 On each accepted tuser beat, pwm_slot SHALL increment modulo P, and bright and mode SHALL latch into frame registers.
REQ-033 That frame, including its tuser pixel, SHALL use the new values; beats already in S1 SHALL complete with the old values.
REQ-034 Back-to-back tuser beats SHALL each increment pwm_slot.
REQ-035 tlast SHALL pass through without affecting addressing.

Reset
REQ-036 While rst_n is low:
- v_m_tvalid, v_m_tdata, v_m_tlast, v_m_tuser = 0.
- Word, lane and stage valids = 0.
- Frame brightness = 0.
- pwm_slot = P-1, so the first frame uses slot 0.
REQ-037 v_s_tready SHALL be 1 during and after reset.
REQ-038 Reset asserted mid-frame SHALL discard in-flight beats with no output beat emitted.

Verification
REQ-039 NCH=2, PB=3, bright={8,0}, mode 0, ch0 word0=0xFFFF0000, one frame of 4 pixels 0xABCD -> outputs 0xABCD,0,(word1 lanes), latency 2.
REQ-040 bright0=4 over 8 frames -> ch0 lit only in slots 1,3,5,7; bright0=9 -> lit all 8 slots.
REQ-041 Hold v_m_tready low 5 cycles mid-frame with ch0 word=0x1234F0F0 -> no beat lost or duplicated, data matches unstalled run, bram_en low during stall.
REQ-042 mode=1, mask all-ones, bright=8 -> all output pixels 0; with bright=0 -> pixels pass unchanged.
REQ-043 DEPTH=4, PPW=2, 10-pixel frame -> addresses 0,0,4,4,8,8,12,12,0,0.
REQ-044 Assert rst_n low with 2 beats in flight -> v_m_tvalid 0 next cycle; the next tuser frame restarts at address 0, slot 0.
